// File: rtl/tetris_key_conditioner_if.sv
// Button/request bundle between the board pins, the key conditioner and the game core.
// slave is the conditioner's view; master is the board/core side.
interface tetris_key_conditioner_if;
  logic enable;
  logic raw_left_n;
  logic raw_right_n;
  logic raw_rotate_n;
  logic key_left;
  logic key_right;
  logic key_rotate;
  logic held_left;
  logic held_right;

  modport master (
    output enable,
    output raw_left_n,
    output raw_right_n,
    output raw_rotate_n,
    input  key_left,
    input  key_right,
    input  key_rotate,
    input  held_left,
    input  held_right
  );

  modport slave (
    input  enable,
    input  raw_left_n,
    input  raw_right_n,
    input  raw_rotate_n,
    output key_left,
    output key_right,
    output key_rotate,
    output held_left,
    output held_right
  );
endinterface

// File: rtl/tetris_key_conditioner.sv
// Synchronises, debounces and edge-detects the push buttons on the frame clock.
// Horizontal keys also get delayed auto-shift followed by auto-repeat.
module tetris_key_conditioner #(
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned DAS_DELAY       = 10,
  parameter int unsigned ARR_PERIOD      = 3
) (
  input  logic                     clock_framerate,
  input  logic                     resetn,
  tetris_key_conditioner_if.slave  keys_io
);

  typedef enum logic [1:0] {StIdle, StDas, StRepeat} hstate_e;

  localparam logic [3:0] DbLast  = 4'(DEBOUNCE_FRAMES - 1);
  localparam logic [4:0] DasLast = 5'(DAS_DELAY - 1);
  localparam logic [4:0] ArrLast = 5'(ARR_PERIOD - 1);

  // Key index: 0 = left, 1 = right, 2 = rotate.
  logic [2:0] raw_pressed;
  logic [2:0] s1_q, s2_q;
  logic [2:0] db_q, db_d, dbd_q;
  logic [3:0] cnt_q [3];
  logic [3:0] cnt_d [3];

  hstate_e    state_q [2];
  hstate_e    state_d [2];
  logic [4:0] t_q [2];
  logic [4:0] t_d [2];

  logic [2:0] key_q, key_d;
  logic [1:0] held_q, held_d;

  assign raw_pressed = ~{keys_io.raw_rotate_n, keys_io.raw_right_n, keys_io.raw_left_n};

  always_comb begin
    db_d = db_q;
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = 4'd0;
      if (s2_q[k] != db_q[k]) begin
        if (cnt_q[k] == DbLast) begin
          db_d[k] = s2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 4'd1;
        end
      end
    end
  end

  // A horizontal FSM only runs while its own key is down, the other is up and input is enabled.
  always_comb begin
    key_d = 3'b000;
    for (int h = 0; h < 2; h++) begin
      state_d[h] = state_q[h];
      t_d[h]     = t_q[h];
      if (!db_q[h] || !keys_io.enable || db_q[1-h]) begin
        state_d[h] = StIdle;
        t_d[h]     = 5'd0;
      end else begin
        unique case (state_q[h])
          StIdle: begin
            if (!dbd_q[h]) begin
              key_d[h]   = 1'b1;
              t_d[h]     = 5'd0;
              state_d[h] = StDas;
            end
          end
          StDas: begin
            if (t_q[h] == DasLast) begin
              key_d[h]   = 1'b1;
              t_d[h]     = 5'd0;
              state_d[h] = StRepeat;
            end else begin
              t_d[h] = t_q[h] + 5'd1;
            end
          end
          StRepeat: begin
            if (t_q[h] == ArrLast) begin
              key_d[h] = 1'b1;
              t_d[h]   = 5'd0;
            end else begin
              t_d[h] = t_q[h] + 5'd1;
            end
          end
          default: begin
            state_d[h] = StIdle;
            t_d[h]     = 5'd0;
          end
        endcase
      end
    end
    key_d[2] = keys_io.enable & db_q[2] & ~dbd_q[2];
    held_d   = keys_io.enable ? db_q[1:0] : 2'b00;
  end

  always_ff @(posedge clock_framerate) begin
    if (!resetn) begin
      s1_q   <= 3'b000;
      s2_q   <= 3'b000;
      db_q   <= 3'b000;
      dbd_q  <= 3'b000;
      key_q  <= 3'b000;
      held_q <= 2'b00;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= 4'd0;
      end
      for (int h = 0; h < 2; h++) begin
        state_q[h] <= StIdle;
        t_q[h]     <= 5'd0;
      end
    end else begin
      s1_q   <= raw_pressed;
      s2_q   <= s1_q;
      db_q   <= db_d;
      dbd_q  <= db_q;
      key_q  <= key_d;
      held_q <= held_d;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      for (int h = 0; h < 2; h++) begin
        state_q[h] <= state_d[h];
        t_q[h]     <= t_d[h];
      end
    end
  end

  assign keys_io.key_left   = key_q[0];
  assign keys_io.key_right  = key_q[1];
  assign keys_io.key_rotate = key_q[2];
  assign keys_io.held_left  = held_q[0];
  assign keys_io.held_right = held_q[1];

endmodule

// File: tb/tb_tetris_key_conditioner.sv
// Directed bench: expected pulse frames are queued when a press is driven and
// every output is compared against the queue heads once per frame.
module tb_tetris_key_conditioner;
  logic clock_framerate = 1'b0;
  logic resetn;

  tetris_key_conditioner_if bus ();

  tetris_key_conditioner #(
    .DEBOUNCE_FRAMES (2),
    .DAS_DELAY       (10),
    .ARR_PERIOD      (3)
  ) dut (
    .clock_framerate (clock_framerate),
    .resetn          (resetn),
    .keys_io         (bus)
  );

  always #5 clock_framerate = ~clock_framerate;

  int n_assert = 0;
  int n_fail   = 0;
  int frame    = 0;
  int q_left[$];
  int q_right[$];
  int q_rot[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at frame %0d", tag, obs, exp, frame);
    end
  endtask

  // Advance one frame and compare the three pulse outputs with the scoreboard.
  task automatic step();
    bit e;
    @(posedge clock_framerate);
    #1;
    frame++;
    e = (q_left.size() > 0) && (q_left[0] == frame);
    chk("key_left", 32'(bus.key_left), 32'(e));
    if (e) void'(q_left.pop_front());
    e = (q_right.size() > 0) && (q_right[0] == frame);
    chk("key_right", 32'(bus.key_right), 32'(e));
    if (e) void'(q_right.pop_front());
    e = (q_rot.size() > 0) && (q_rot[0] == frame);
    chk("key_rotate", 32'(bus.key_rotate), 32'(e));
    if (e) void'(q_rot.pop_front());
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int c;
    int p;
    int p2;
    int held;

    bus.enable       = 1'b1;
    bus.raw_left_n   = 1'b1;
    bus.raw_right_n  = 1'b1;
    bus.raw_rotate_n = 1'b1;
    resetn           = 1'b0;
    steps(2);
    chk("rst_held_left", 32'(bus.held_left), 0);
    chk("rst_held_right", 32'(bus.held_right), 0);
    resetn = 1'b1;
    steps(4);

    // Single tap: 6 sampled frames of left.
    c = frame;
    bus.raw_left_n = 1'b0;
    q_left.push_back(c + 5);
    held = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (bus.held_left === 1'b1) held++;
      if (i == 5) bus.raw_left_n = 1'b1;
    end
    chk("tap_held_frames", 32'(held), 6);
    steps(4);

    // Bounce on rotate, then a stable press.
    for (int i = 0; i < 10; i++) begin
      bus.raw_rotate_n = (i % 2 == 1);
      step();
    end
    c = frame;
    bus.raw_rotate_n = 1'b0;
    q_rot.push_back(c + 5);
    steps(10);
    bus.raw_rotate_n = 1'b1;
    steps(8);

    // Auto-repeat on right: 27 sampled frames; FSM stays active up to c+31.
    c = frame;
    p = c + 5;
    bus.raw_right_n = 1'b0;
    q_right.push_back(p);
    for (int t = p + 10; t <= c + 31; t += 3) q_right.push_back(t);
    steps(27);
    bus.raw_right_n = 1'b1;
    steps(10);

    // Conflict: right pressed while left repeats.
    c = frame;
    p = c + 5;
    bus.raw_left_n = 1'b0;
    q_left.push_back(p);
    q_left.push_back(p + 10);
    q_left.push_back(p + 13);
    steps(p + 11 - frame);
    bus.raw_right_n = 1'b0;
    steps(14);
    chk("conflict_held_right", 32'(bus.held_right), 1);
    bus.raw_right_n = 1'b1;
    steps(10);
    chk("conflict_held_left", 32'(bus.held_left), 1);
    bus.raw_left_n = 1'b1;
    steps(8);
    c = frame;
    bus.raw_left_n = 1'b0;
    q_left.push_back(c + 5);
    steps(4);
    bus.raw_left_n = 1'b1;
    steps(8);

    // Enable gating: keys pressed while disabled never pulse.
    bus.enable       = 1'b0;
    bus.raw_rotate_n = 1'b0;
    bus.raw_left_n   = 1'b0;
    steps(8);
    chk("disabled_held_left", 32'(bus.held_left), 0);
    bus.enable = 1'b1;
    steps(8);
    chk("enabled_held_left", 32'(bus.held_left), 1);
    bus.raw_rotate_n = 1'b1;
    bus.raw_left_n   = 1'b1;
    steps(8);
    c = frame;
    bus.raw_rotate_n = 1'b0;
    q_rot.push_back(c + 5);
    steps(6);
    bus.raw_rotate_n = 1'b1;
    steps(8);

    // Reset during REPEAT with left still held.
    c = frame;
    p = c + 5;
    bus.raw_left_n = 1'b0;
    q_left.push_back(p);
    q_left.push_back(p + 10);
    q_left.push_back(p + 13);
    steps(p + 14 - frame);
    resetn = 1'b0;
    step();
    chk("midrst_key_left", 32'(bus.key_left), 0);
    chk("midrst_held_left", 32'(bus.held_left), 0);
    resetn = 1'b1;
    p2 = frame + 5;
    q_left.push_back(p2);
    q_left.push_back(p2 + 10);
    q_left.push_back(p2 + 13);
    q_left.push_back(p2 + 16);
    steps(p2 + 14 - frame);
    bus.raw_left_n = 1'b1;
    steps(10);

    chk("sb_left_empty", 32'(q_left.size()), 0);
    chk("sb_right_empty", 32'(q_right.size()), 0);
    chk("sb_rot_empty", 32'(q_rot.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
